// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word,
// rejects malformed requests, and queues legal words in a 2-entry FIFO
// tagged with consecutive instruction-memory byte addresses.

package types;
    typedef enum logic [2:0] {
        R_TYPE       = 3'd0,
        I_TYPE       = 3'd1,
        S_TYPE       = 3'd2,
        B_TYPE       = 3'd3,
        U_TYPE       = 3'd4,
        J_TYPE       = 3'd5,
        INVALID_TYPE = 3'd6
    } inst_format_e;
endpackage

module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  types::inst_format_e format_i,
    input  logic [6:0]          opcode_i,
    input  logic [2:0]          funct3_i,
    input  logic [6:0]          funct7_i,
    input  logic [4:0]          rs1_i,
    input  logic [4:0]          rs2_i,
    input  logic [4:0]          rd_i,
    input  logic [31:0]         imm_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [31:0]         inst_o,
    output logic [31:0]         addr_o,
    output logic [7:0]          err_cnt_o
);

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    // Buffer entry 0 is always the head; entry 1 only holds data when full.
    logic [1:0][31:0] buf_inst_q, buf_inst_d;
    logic [1:0][31:0] buf_addr_q, buf_addr_d;
    logic [1:0]       count_q, count_d;
    logic [31:0]      addr_cnt_q, addr_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [31:0] enc_word;
    logic        legal;
    logic        in_fire;
    logic        out_fire;
    logic        push;
    logic        reject;
    logic [1:0]  push_idx;

    assign ready_o   = (count_q != 2'd2);
    assign valid_o   = (count_q != 2'd0);
    assign inst_o    = buf_inst_q[0];
    assign addr_o    = valid_o ? buf_addr_q[0] : addr_cnt_q;
    assign err_cnt_o = err_cnt_q;

    // Pack the request fields according to the instruction format.
    always_comb begin
        enc_word = 32'h0;
        unique case (format_i)
            types::R_TYPE: enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            types::I_TYPE: enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            types::S_TYPE: enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            types::B_TYPE: enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                                       imm_i[4:1], imm_i[11], opcode_i};
            types::U_TYPE: enc_word = {imm_i[31:12], rd_i, opcode_i};
            types::J_TYPE: enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                                       rd_i, opcode_i};
            default:       enc_word = 32'h0;
        endcase
    end

    // Legality: the immediate must be representable in the format's field
    // (sign bits above the field all equal, branch/jump offsets even).
    always_comb begin
        legal = 1'b0;
        unique case (format_i)
            types::R_TYPE: legal = 1'b1;
            types::I_TYPE,
            types::S_TYPE: legal = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
            types::B_TYPE: legal = !imm_i[0] &&
                                   ((imm_i[31:12] == '0) || (imm_i[31:12] == '1));
            types::U_TYPE: legal = (imm_i[11:0] == 12'h000);
            types::J_TYPE: legal = !imm_i[0] &&
                                   ((imm_i[31:20] == '0) || (imm_i[31:20] == '1));
            default:       legal = 1'b0;
        endcase
        if (opcode_i[1:0] != 2'b11) begin
            legal = 1'b0;
        end
    end

    // Handshakes; clear wins over both sides in the same cycle.
    assign in_fire  = valid_i & ready_o & ~clear_i;
    assign out_fire = valid_o & ready_i & ~clear_i;
    assign push     = in_fire & legal;
    assign reject   = in_fire & ~legal;
    assign push_idx = count_q - {1'b0, out_fire};

    // Next-state for the FIFO, address counter and error counter.
    always_comb begin
        buf_inst_d = buf_inst_q;
        buf_addr_d = buf_addr_q;
        count_d    = count_q;
        addr_cnt_d = addr_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (clear_i) begin
            count_d    = 2'd0;
            addr_cnt_d = BASE_ADDR;
            err_cnt_d  = 8'h00;
        end else begin
            if (out_fire) begin
                addr_cnt_d = addr_cnt_q + STEP;
                // Shift only when a second word is waiting, so inst_o keeps
                // its last value once the buffer drains.
                if (count_q == 2'd2) begin
                    buf_inst_d[0] = buf_inst_q[1];
                    buf_addr_d[0] = buf_addr_q[1];
                end
            end
            if (push) begin
                // Address = head address plus one step per word already
                // queued ahead of this one; holds with or without a pop.
                buf_inst_d[push_idx[0]] = enc_word;
                buf_addr_d[push_idx[0]] = addr_cnt_q + ((count_q == 2'd0) ? 32'h0 : STEP);
            end
            count_d = count_q - {1'b0, out_fire} + {1'b0, push};
            if (reject && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'h01;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_inst_q <= '0;
            buf_addr_q <= '0;
            count_q    <= 2'd0;
            addr_cnt_q <= BASE_ADDR;
            err_cnt_q  <= 8'h00;
        end else begin
            buf_inst_q <= buf_inst_d;
            buf_addr_q <= buf_addr_d;
            count_q    <= count_d;
            addr_cnt_q <= addr_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule
